cordic_seq: RTL and testbench
=============================

CORDIC_SEQ -- requirements
Module: cordic_seq

Interface
REQ-001 Parameter W, default 16: angle magnitude width; core result width is W+1.
REQ-002 Parameter ITERS, default 15, legal range 1..15: number of core iteration cycles run per request.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  request accepted when in_valid & in_ready are both high at a clock edge.
REQ-007 in_theta  input  W  angle magnitude, in core angle units, within one quadrant.
REQ-008 in_sign  input  1  rotation direction passed to the core.
REQ-009 in_quad  input  2  quadrant index applied to the result (0..3 = 0/90/180/270 degrees).
REQ-010 core_rst  output  1  drives the iterative core's load/reset input.
REQ-011 core_theta  output  W  angle to the core, valid while core_rst=1.
REQ-012 core_sign  output  1  sign to the core, valid while core_rst=1.
REQ-013 core_cos, core_sin  input  W+1 each  signed core results.
REQ-014 out_valid  output  1  result available.
REQ-015 out_ready  input  1  consumer accepts the result when out_valid & out_ready are both high.
REQ-016 out_cos, out_sin  output  W+2 each  signed, quadrant-corrected results.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have four states: IDLE, LAUNCH, RUN, DONE.
REQ-019 IDLE: in_ready=1 only in IDLE; on accept, latch theta, sign and quad, then go to LAUNCH.
REQ-020 LAUNCH: lasts exactly 1 cycle; core_rst=1, core_theta/core_sign driven from the latched registers; clear the iteration counter; go to RUN.
REQ-021 RUN: core_rst=0; the counter increments each cycle; at the edge ending the cycle with counter=ITERS-1, capture the corrected results and go to DONE.
REQ-022 Latency: out_valid SHALL rise exactly ITERS+1 edges after the accept edge (16 for the default).
REQ-023 DONE: out_valid=1; out_cos/out_sin held stable; on out_valid & out_ready go to IDLE. A new request is accepted no earlier than the following cycle (no same-cycle turnaround).
REQ-024 Quadrant correction SHALL first sign-extend c=core_cos and s=core_sin to W+2 bits, then apply: q0 (c,s); q1 (-s,c); q2 (-c,-s); q3 (s,-c).
REQ-025 Negation SHALL be two's complement at W+2 bits, so no overflow is possible for any W+1-bit input.
REQ-026 core_rst SHALL be 0 in RUN and DONE, and 1 in IDLE (holds the core in load while idle).
REQ-027 core_theta/core_sign SHALL always reflect the latched registers; in IDLE these equal the last accepted values.
REQ-028 in_valid outside IDLE SHALL be ignored: no latch, in_ready=0. out_ready while out_valid=0 SHALL be ignored.
REQ-029 Input changes during LAUNCH/RUN/DONE SHALL NOT affect the result in flight.
REQ-030 Counter width SHALL be 4 bits; it does not wrap within a request because ITERS<=15.

Reset
REQ-031 While reset=1: state=IDLE, out_valid=0, busy=0, in_ready=0, core_rst=1, counter=0, out_cos=0, out_sin=0, latched theta/sign/quad=0.
REQ-032 in_ready SHALL rise in the first cycle after reset deasserts.
REQ-033 Reset asserted in any state, including mid-RUN or DONE with out_valid=1, SHALL abort the operation: the result is discarded and no out handshake occurs.

Verification
REQ-034 Reset: hold reset 3 cycles -> out_valid=0, core_rst=1, out_cos=out_sin=0; in_ready=1 the cycle after release.
REQ-035 Latency: ITERS=15, quad=0, stub core drives cos=17'h04000, sin=17'h01000 -> core_rst high exactly 1 cycle; out_valid rises on the 16th edge after accept; out_cos=18'h04000, out_sin=18'h01000.
REQ-036 Quadrants: same stub, quad=1 -> (18'h3F000, 18'h04000); quad=2 -> (18'h3C000, 18'h3F000); quad=3 -> (18'h01000, 18'h3C000).
REQ-037 Back-pressure: out_ready=0 for 10 cycles in DONE, in_valid held high -> outputs stable, in_ready=0; on out_ready=1, IDLE next cycle, and the pending request is accepted one cycle later.
REQ-038 Abort: assert reset at RUN counter=7 -> out_valid never asserts for that request; the next request completes with normal latency and correct values.
REQ-039 Input isolation: change in_theta/in_quad every cycle during RUN -> the result matches the values latched at accept.

Source files
------------

// File: rtl/cordic_seq_if.sv
// Request/result handshake bundle for the sequential CORDIC wrapper.
// Valid/ready: a transfer happens on a rising clock edge where valid and ready are both high;
// the producer holds its payload stable from valid rising until that edge.
interface cordic_seq_if #(
  parameter int W = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_theta;
  logic           in_sign;
  logic [1:0]     in_quad;
  logic           out_valid;
  logic           out_ready;
  logic [W+1:0]   out_cos;
  logic [W+1:0]   out_sin;

  modport master (
    output in_valid, in_theta, in_sign, in_quad, out_ready,
    input  in_ready, out_valid, out_cos, out_sin
  );

  modport slave (
    input  in_valid, in_theta, in_sign, in_quad, out_ready,
    output in_ready, out_valid, out_cos, out_sin
  );
endinterface

// File: rtl/cordic_seq.sv
// Sequencer around an iterative CORDIC core: latches a request, loads and runs the core
// for ITERS cycles, then presents the quadrant-corrected result until it is taken.
module cordic_seq #(
  parameter int W     = 16,
  parameter int ITERS = 15
) (
  input  logic          clock,
  input  logic          reset,
  cordic_seq_if.slave   bus,
  output logic          core_rst,
  output logic [W-1:0]  core_theta,
  output logic          core_sign,
  input  logic [W:0]    core_cos,
  input  logic [W:0]    core_sin,
  output logic          busy,
  output logic [1:0]    state_dbg
);
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [3:0]    cnt;
  logic [W-1:0]  theta_q;
  logic          sign_q;
  logic [1:0]    quad_q;
  logic [W+1:0]  cos_q, sin_q;
  logic [W+1:0]  c_ext, s_ext, fix_cos, fix_sin;
  logic          accept, last_iter;

  assign accept    = (state == IDLE) && bus.in_valid && !reset;
  assign last_iter = (cnt == 4'(ITERS - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = LAUNCH;
      LAUNCH:  state_nx = RUN;
      RUN:     if (last_iter) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Widen before negating so -(-2^W) still fits.
  always_comb begin
    c_ext   = {core_cos[W], core_cos};
    s_ext   = {core_sin[W], core_sin};
    fix_cos = c_ext;
    fix_sin = s_ext;
    case (quad_q)
      2'd1: begin fix_cos = -s_ext; fix_sin = c_ext;  end
      2'd2: begin fix_cos = -c_ext; fix_sin = -s_ext; end
      2'd3: begin fix_cos = s_ext;  fix_sin = -c_ext; end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      theta_q <= '0;
      sign_q  <= 1'b0;
      quad_q  <= 2'd0;
      cos_q   <= '0;
      sin_q   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        theta_q <= bus.in_theta;
        sign_q  <= bus.in_sign;
        quad_q  <= bus.in_quad;
      end
      if (state == LAUNCH) cnt <= 4'd0;
      else if (state == RUN) cnt <= cnt + 4'd1;
      if (state == RUN && last_iter) begin
        cos_q <= fix_cos;
        sin_q <= fix_sin;
      end
    end
  end

  // Handshake outputs are gated by reset so nothing is offered or accepted during it.
  assign bus.in_ready  = (state == IDLE) && !reset;
  assign bus.out_valid = (state == DONE) && !reset;
  assign bus.out_cos   = cos_q;
  assign bus.out_sin   = sin_q;
  assign busy          = (state != IDLE) && !reset;
  assign core_rst      = reset || (state == IDLE) || (state == LAUNCH);
  assign core_theta    = theta_q;
  assign core_sign     = sign_q;
  assign state_dbg     = state;
endmodule

// File: tb/tb_cordic_seq.sv
// Bench for cordic_seq: stub core, request-level model with expected queue, per-cycle
// compare process, and directed requests with hand-computed results.
module tb_cordic_seq;
  localparam int W     = 16;
  localparam int ITERS = 15;

  // ---- clock / reset ----
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cordic_seq_if #(.W(W)) bus ();
  logic          core_rst;
  logic [W-1:0]  core_theta;
  logic          core_sign;
  logic [W:0]    core_cos, core_sin;
  logic          busy;
  logic [1:0]    state_dbg;

  cordic_seq #(.W(W), .ITERS(ITERS)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus.slave),
    .core_rst   (core_rst),
    .core_theta (core_theta),
    .core_sign  (core_sign),
    .core_cos   (core_cos),
    .core_sin   (core_sin),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---- stub core: loads while core_rst=1, then holds cos={0,theta}, sin=+-(theta>>2) ----
  logic [W-1:0] stub_theta = '0;
  logic         stub_sign  = 1'b0;

  function automatic logic [W:0] stub_cos_f(input logic [W-1:0] t);
    return {1'b0, t};
  endfunction

  function automatic logic [W:0] stub_sin_f(input logic [W-1:0] t, input logic sg);
    logic [W:0] m;
    m = {1'b0, t} >> 2;
    return sg ? (0 - m) : m;
  endfunction

  always @(posedge clock) begin
    if (core_rst) begin
      stub_theta <= core_theta;
      stub_sign  <= core_sign;
    end
  end
  assign core_cos = stub_cos_f(stub_theta);
  assign core_sin = stub_sin_f(stub_theta, stub_sign);

  // ---- scoreboard ----
  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Result the consumer must see: rotate the core vector by quad*90 degrees.
  function automatic logic [2*W+3:0] expect_pair(input logic [W-1:0] t, input logic sg,
                                                 input logic [1:0] q);
    int c, s, rc, rs;
    logic [W+1:0] ec, es;
    c = $signed(stub_cos_f(t));
    s = $signed(stub_sin_f(t, sg));
    case (q)
      2'd0:    begin rc = c;  rs = s;  end
      2'd1:    begin rc = -s; rs = c;  end
      2'd2:    begin rc = -c; rs = -s; end
      default: begin rc = s;  rs = -c; end
    endcase
    ec = rc[W+1:0];
    es = rs[W+1:0];
    return {ec, es};
  endfunction

  logic [2*W+3:0] exp_q[$];
  bit             pend   = 0;
  int             n      = 0;
  bit             chk_en = 0;
  logic [W-1:0]   m_theta = '0;
  logic           m_sign  = 1'b0;
  logic [W+1:0]   m_cos   = '0;
  logic [W+1:0]   m_sin   = '0;

  // Model: n counts edges since the accept edge; result visible once n reaches ITERS+1.
  always @(posedge clock) begin
    if (reset) begin
      pend = 0; n = 0; m_theta = '0; m_sign = 1'b0; m_cos = '0; m_sin = '0;
      exp_q.delete();
      chk_en = 1;
    end else if (pend) begin
      if (n >= ITERS + 1 && bus.out_ready) begin
        pend = 0;
        void'(exp_q.pop_front());
      end else begin
        n++;
        if (n == ITERS + 1) {m_cos, m_sin} = exp_q[0];
      end
    end else if (bus.in_valid) begin
      pend    = 1;
      n       = 0;
      m_theta = bus.in_theta;
      m_sign  = bus.in_sign;
      exp_q.push_back(expect_pair(bus.in_theta, bus.in_sign, bus.in_quad));
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("in_ready",   bus.in_ready,  !reset && !pend);
      check("out_valid",  bus.out_valid, !reset && pend && n >= ITERS + 1);
      check("busy",       busy,          !reset && pend);
      check("core_rst",   core_rst,      reset || !pend || n == 0);
      check("core_theta", core_theta,    m_theta);
      check("core_sign",  core_sign,     m_sign);
      check("out_cos",    bus.out_cos,   m_cos);
      check("out_sin",    bus.out_sin,   m_sin);
    end
  end

  // ---- driver tasks ----
  task automatic send(input logic [W-1:0] t, input logic sg, input logic [1:0] q);
    bit ok;
    ok = 0;
    @(negedge clock);
    bus.in_valid = 1'b1; bus.in_theta = t; bus.in_sign = sg; bus.in_quad = q;
    for (int i = 0; i < 50; i++) begin
      if (bus.in_ready) begin ok = 1; break; end
      @(negedge clock);
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (bus.out_valid) break;
    end
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic run_req(input logic [W-1:0] t, input logic sg, input logic [1:0] q,
                         input logic [W+1:0] ec, input logic [W+1:0] es, input string nm);
    int lat;
    send(t, sg, q);
    wait_out(lat);
    check({nm, "_latency"}, lat, 16);
    check({nm, "_cos"}, bus.out_cos, ec);
    check({nm, "_sin"}, bus.out_sin, es);
    take();
  endtask

  // ---- directed stimulus ----
  logic [W+1:0] lit_c[4] = '{18'h04000, 18'h3F000, 18'h3C000, 18'h01000};
  logic [W+1:0] lit_s[4] = '{18'h01000, 18'h04000, 18'h3F000, 18'h3C000};

  initial begin
    int lat;
    bus.in_valid = 1'b0; bus.in_theta = '0; bus.in_sign = 1'b0; bus.in_quad = 2'd0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_core_rst",  core_rst, 1);
    check("rst_out_cos",   bus.out_cos, 0);
    check("rst_out_sin",   bus.out_sin, 0);
    check("rst_in_ready",  bus.in_ready, 0);
    reset = 1'b0;
    #1 check("rel_in_ready", bus.in_ready, 1);

    for (int q = 0; q < 4; q++)
      run_req(16'h4000, 1'b0, 2'(q), lit_c[q], lit_s[q], $sformatf("quad%0d", q));

    // Boundary magnitudes and a negative-sign core result.
    run_req(16'hFFFF, 1'b0, 2'd2, 18'h30001, 18'h3C001, "max_q2");
    run_req(16'h0000, 1'b1, 2'd1, 18'h00000, 18'h00000, "zero_q1");
    run_req(16'h0800, 1'b1, 2'd3, 18'h3FE00, 18'h3F800, "neg_q3");

    // Back-pressure with a second request waiting.
    send(16'h4000, 1'b0, 2'd1);
    wait_out(lat);
    check("bp_latency", lat, 16);
    bus.in_valid = 1'b1; bus.in_theta = 16'h2000; bus.in_sign = 1'b0; bus.in_quad = 2'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_hold_cos", bus.out_cos, 18'h3F000);
      check("bp_hold_sin", bus.out_sin, 18'h04000);
    end
    take();
    check("bp_idle_out_valid", bus.out_valid, 0);
    check("bp_idle_in_ready",  bus.in_ready, 1);
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    check("bp_pending_busy", busy, 1);
    wait_out(lat);
    check("bp2_latency", lat, 16);
    check("bp2_cos", bus.out_cos, 18'h3E000);
    check("bp2_sin", bus.out_sin, 18'h3F800);
    take();

    // Abort in the middle of RUN (counter = 7).
    send(16'h4000, 1'b0, 2'd0);
    repeat (8) @(posedge clock);
    #1 check("abort_busy", busy, 1);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_out_cos", bus.out_cos, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.out_valid) check("abort_no_result", 1, 0);
    end
    run_req(16'h4000, 1'b0, 2'd3, 18'h01000, 18'h3C000, "after_abort");

    // Input isolation: scramble request inputs while the result is in flight.
    send(16'h1000, 1'b1, 2'd2);
    lat = 0;
    while (lat < 40) begin
      @(posedge clock);
      lat++;
      #1;
      bus.in_theta = 16'($urandom);
      bus.in_sign  = 1'($urandom_range(0, 1));
      bus.in_quad  = 2'($urandom_range(0, 3));
      @(negedge clock);
      if (bus.out_valid) break;
    end
    check("iso_latency", lat, 16);
    check("iso_cos", bus.out_cos, 18'h3F000);
    check("iso_sin", bus.out_sin, 18'h00400);
    take();

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end
endmodule
